// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master data-RAM arbiter: FSM states, master ids, lane count.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_e;

    localparam logic MstM0 = 1'b0;
    localparam logic MstM1 = 1'b1;

    localparam int unsigned NumLanes = 4;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the RAM arbiter.
// RAM_ARB_RR_EN selects round-robin ties instead of fixed priority with starve override.
module ram_arb_pick
    import ram_arbiter_pkg::*;
(
    input  arb_state_e state,
    input  logic       m0_req,
    input  logic       m1_req,
`ifdef RAM_ARB_RR_EN
    input  logic       last_served,
`else
    input  logic       starve_hit,
`endif
    output logic       gnt0,
    output logic       gnt1
);

    logic tie_to_m1;

    always_comb begin
`ifdef RAM_ARB_RR_EN
        tie_to_m1 = (last_served == MstM0);
`else
        tie_to_m1 = starve_hit;
`endif
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            StOwn0: gnt0 = m0_req;
            StOwn1: gnt1 = m1_req;
            default: begin
                if (m0_req && m1_req) begin
                    gnt0 = !tie_to_m1;
                    gnt1 = tie_to_m1;
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the byte-banked data RAM with locked bursts and return routing.
// RAM_ARB_RR_EN: round-robin ties; otherwise fixed m0 priority with m1 starvation override.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RAM_AW     = 11,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                m0_req,
    input  logic                m0_lock,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [NumLanes-1:0] m0_wstrb,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_lock,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [NumLanes-1:0] m1_wstrb,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                ram_en,
    output logic [NumLanes-1:0] ram_we,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    arb_state_e          state_q, state_d;
    logic                rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DATA_W-1:0]   hold0_q, hold0_d, hold1_q, hold1_d;
    logic                gnt0_raw, gnt1_raw;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [NumLanes-1:0] sel_wstrb;
    logic                unused_addr_bits;

`ifdef RAM_ARB_RR_EN
    logic last_q, last_d;

    ram_arb_pick u_pick (
        .state       (state_q),
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .last_served (last_q),
        .gnt0        (gnt0_raw),
        .gnt1        (gnt1_raw)
    );

    always_comb begin
        last_d = last_q;
        if (m1_gnt) begin
            last_d = MstM1;
        end else if (m0_gnt) begin
            last_d = MstM0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_q <= MstM1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

    logic [StarveW-1:0] starve_q, starve_d;
    logic               starve_hit;

    assign starve_hit = (starve_q == StarveW'(STARVE_MAX));

    ram_arb_pick u_pick (
        .state      (state_q),
        .m0_req     (m0_req),
        .m1_req     (m1_req),
        .starve_hit (starve_hit),
        .gnt0       (gnt0_raw),
        .gnt1       (gnt1_raw)
    );

    // Counts while m1 waits, including behind an m0 lock; only an m1 grant clears it.
    always_comb begin
        starve_d = starve_q;
        if (m1_gnt) begin
            starve_d = '0;
        end else if (m1_req && !starve_hit) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Reset is gated straight into the outputs so nothing leaks during the reset cycle.
    assign m0_gnt = gnt0_raw & rstn;
    assign m1_gnt = gnt1_raw & rstn;

    always_comb begin
        sel_we    = m1_gnt ? m1_we    : m0_we;
        sel_addr  = m1_gnt ? m1_addr  : m0_addr;
        sel_wstrb = m1_gnt ? m1_wstrb : m0_wstrb;
        ram_en    = m0_gnt | m1_gnt;
        ram_we    = ram_en ? (sel_wstrb & {NumLanes{sel_we}}) : '0;
        ram_addr  = sel_addr[RAM_AW+1:2];
        ram_wdata = m1_gnt ? m1_wdata : m0_wdata;
    end

    assign unused_addr_bits = ^{m0_addr[ADDR_W-1:RAM_AW+2], m0_addr[1:0],
                                m1_addr[ADDR_W-1:RAM_AW+2], m1_addr[1:0]};

    always_comb begin
        state_d = StIdle;
        if (m0_gnt && m0_lock) begin
            state_d = StOwn0;
        end else if (m1_gnt && m1_lock) begin
            state_d = StOwn1;
        end
        rv0_d   = m0_gnt;
        rv1_d   = m1_gnt;
        hold0_d = rv0_q ? ram_rdata : hold0_q;
        hold1_d = rv1_q ? ram_rdata : hold1_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            state_q <= state_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
        end
    end

    always_comb begin
        m0_rvalid = rv0_q & rstn;
        m1_rvalid = rv1_q & rstn;
        m0_rdata  = !rstn ? '0 : (rv0_q ? ram_rdata : hold0_q);
        m1_rdata  = !rstn ? '0 : (rv1_q ? ram_rdata : hold1_q);
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: bench-side RAM, a rule-level reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_ram_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int RAM_AW     = 11;
    localparam int STARVE_MAX = 8;
    localparam int Words      = 1 << RAM_AW;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RAM_AW     (RAM_AW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .m0_req    (m0_req),
        .m0_lock   (m0_lock),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wstrb  (m0_wstrb),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_lock   (m1_lock),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wstrb  (m1_wstrb),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Bench RAM: read-first, one-cycle synchronous read, byte-lane writes.
    logic [31:0] ram_mem [Words];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram_mem[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state.
    int          mdl_owner = 0;      // 0 nobody holds a lock, 1 m0, 2 m1
    int          mdl_wait = 0;       // cycles m1 has waited, saturating
    bit          mdl_last_m1 = 1'b1;
    bit          mdl_rv0 = 1'b0, mdl_rv1 = 1'b0;
    logic [31:0] mdl_ret0 = 0, mdl_ret1 = 0, mdl_hold0 = 0, mdl_hold1 = 0;
    logic [31:0] mdl_mem [Words];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % Words);
    endfunction

    function automatic void mdl_grants(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rstn) return;
        if (mdl_owner == 1) g0 = m0_req;
        else if (mdl_owner == 2) g1 = m1_req;
        else if (m0_req && m1_req) begin
`ifdef RAM_ARB_RR_EN
            if (mdl_last_m1) g0 = 1'b1;
            else g1 = 1'b1;
`else
            if (mdl_wait >= STARVE_MAX) g1 = 1'b1;
            else g0 = 1'b1;
`endif
        end else begin
            g0 = m0_req;
            g1 = m1_req;
        end
    endfunction

    task automatic mdl_access(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wd, output logic [31:0] ret);
        int w;
        w = widx(addr);
        ret = mdl_mem[w];
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mdl_mem[w][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic mdl_step();
        bit g0, g1;
        mdl_grants(g0, g1);
        if (!rstn) begin
            mdl_owner = 0; mdl_wait = 0; mdl_last_m1 = 1'b1;
            mdl_rv0 = 1'b0; mdl_rv1 = 1'b0; mdl_hold0 = 0; mdl_hold1 = 0;
        end else begin
            if (mdl_rv0) mdl_hold0 = mdl_ret0;
            if (mdl_rv1) mdl_hold1 = mdl_ret1;
            mdl_rv0 = g0;
            mdl_rv1 = g1;
            if (g0) mdl_access(m0_we, m0_addr, m0_wstrb, m0_wdata, mdl_ret0);
            if (g1) mdl_access(m1_we, m1_addr, m1_wstrb, m1_wdata, mdl_ret1);
            if (g0 && m0_lock) mdl_owner = 1;
            else if (g1 && m1_lock) mdl_owner = 2;
            else mdl_owner = 0;
            if (g1) mdl_wait = 0;
            else if (m1_req && mdl_wait < STARVE_MAX) mdl_wait++;
            if (g1) mdl_last_m1 = 1'b1;
            else if (g0) mdl_last_m1 = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        bit g0, g1;
        logic [3:0] exp_we;
        mdl_grants(g0, g1);
        check("m0_gnt", m0_gnt, g0);
        check("m1_gnt", m1_gnt, g1);
        check("ram_en", ram_en, g0 | g1);
        exp_we = g0 ? (m0_we ? m0_wstrb : 4'h0) : (g1 ? (m1_we ? m1_wstrb : 4'h0) : 4'h0);
        check("ram_we", ram_we, exp_we);
        if (g0) begin
            check("ram_addr", ram_addr, widx(m0_addr));
            check("ram_wdata", ram_wdata, m0_wdata);
        end else if (g1) begin
            check("ram_addr", ram_addr, widx(m1_addr));
            check("ram_wdata", ram_wdata, m1_wdata);
        end
        if (rstn) begin
            check("m0_rvalid", m0_rvalid, mdl_rv0);
            check("m1_rvalid", m1_rvalid, mdl_rv1);
            check("m0_rdata", m0_rdata, mdl_rv0 ? mdl_ret0 : mdl_hold0);
            check("m1_rdata", m1_rdata, mdl_rv1 ? mdl_ret1 : mdl_hold1);
        end else begin
            check("rst_m0_rvalid", m0_rvalid, 0);
            check("rst_m1_rvalid", m1_rvalid, 0);
            check("rst_m0_rdata", m0_rdata, 0);
            check("rst_m1_rdata", m1_rdata, 0);
        end
    endtask

    initial forever begin
        @(posedge clk);
        mdl_step();
    end

    initial forever begin
        @(negedge clk);
        #2;
        compare_outputs();
    end

    task automatic idle_inputs();
        m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = 0; m0_wstrb = 0; m0_wdata = 0;
        m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = 0; m1_wstrb = 0; m1_wdata = 0;
    endtask

    task automatic set_m0(input logic lock, input logic we, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wd);
        m0_req = 1; m0_lock = lock; m0_we = we; m0_addr = addr; m0_wstrb = strb; m0_wdata = wd;
    endtask

    task automatic set_m1(input logic lock, input logic we, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wd);
        m1_req = 1; m1_lock = lock; m1_we = we; m1_addr = addr; m1_wstrb = strb; m1_wdata = wd;
    endtask

    task automatic drop_m0();
        m0_req = 0; m0_lock = 0;
    endtask

    task automatic drop_m1();
        m1_req = 0; m1_lock = 0;
    endtask

    initial begin
        bit exp_m1;
        for (int w = 0; w < Words; w++) begin
            ram_mem[w] = 32'h0;
            mdl_mem[w] = 32'h0;
        end
        ram_mem[4] = 32'hDEADBEEF;
        mdl_mem[4] = 32'hDEADBEEF;
        idle_inputs();
        rstn = 0;

        // Reset state, with a request pending that must not be honoured.
        repeat (2) @(negedge clk);
        set_m0(0, 1, 32'h10, 4'hF, 32'h0BADF00D);
        #3;
        check("reset_m0_gnt", m0_gnt, 0);
        check("reset_ram_en", ram_en, 0);
        check("reset_ram_we", ram_we, 0);
        check("reset_m0_rvalid", m0_rvalid, 0);
        @(negedge clk);
        idle_inputs();
        rstn = 1;

        // Lone m0 read of word 4.
        @(negedge clk);
        set_m0(0, 0, 32'h10, 4'h0, 32'h0);
        #3;
        check("t1_gnt", m0_gnt, 1);
        check("t1_ram_addr", ram_addr, 4);
        @(negedge clk);
        idle_inputs();
        #3;
        check("t1_rvalid", m0_rvalid, 1);
        check("t1_rdata", m0_rdata, 32'hDEADBEEF);

        // m1 half-word write to word 8, then m0 reads it back.
        @(negedge clk);
        set_m1(0, 1, 32'h20, 4'b0011, 32'h12345678);
        #3;
        check("t2_gnt", m1_gnt, 1);
        check("t2_ram_we", ram_we, 4'b0011);
        check("t2_ram_addr", ram_addr, 8);
        @(negedge clk);
        idle_inputs();
        #3;
        check("t2_rvalid", m1_rvalid, 1);
        check("t2_m0_rdata_held", m0_rdata, 32'hDEADBEEF);
        @(negedge clk);
        set_m0(0, 0, 32'h20, 4'h0, 32'h0);
        @(negedge clk);
        idle_inputs();
        #3;
        check("t2_readback", m0_rdata, 32'h00005678);

        // Both held requesting: starvation override (or alternation in round-robin).
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            set_m0(0, 0, 32'h100 + 4 * i, 4'h0, 32'h0);
            set_m1(0, 0, 32'h200, 4'h0, 32'h0);
            #3;
`ifdef RAM_ARB_RR_EN
            exp_m1 = (i % 2 == 0);
`else
            exp_m1 = (i == 8) || (i == 17);
`endif
            check("t3_m1_gnt", m1_gnt, exp_m1);
            check("t3_m0_gnt", m0_gnt, !exp_m1);
        end

        // m1 locked burst of 4 beats shuts m0 out until it ends.
        @(negedge clk);
        idle_inputs();
        set_m1(1, 1, 32'h40, 4'hF, 32'hA0A0A0A0);
        #3;
        check("t4_beat0_m1", m1_gnt, 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            set_m1(i < 3, 1, 32'h40 + 4 * i, 4'hF, 32'hA0A0A0A0 + i);
            set_m0(0, 0, 32'h44, 4'h0, 32'h0);
            #3;
            check("t4_m0_blocked", m0_gnt, 0);
            check("t4_m1_beat", m1_gnt, 1);
        end
        @(negedge clk);
        drop_m1();
        #3;
        check("t4_m0_after", m0_gnt, 1);

        // Reset in the cycle after an m0 read grant, with an m1 write pending.
        @(negedge clk);
        idle_inputs();
        set_m0(0, 0, 32'h10, 4'h0, 32'h0);
        #3;
        check("t5_gnt", m0_gnt, 1);
        @(negedge clk);
        rstn = 0;
        drop_m0();
        set_m1(0, 1, 32'h10, 4'hF, 32'hFFFFFFFF);
        #3;
        check("t5_rvalid", m0_rvalid, 0);
        check("t5_rdata", m0_rdata, 0);
        check("t5_m1_gnt", m1_gnt, 0);
        check("t5_ram_we", ram_we, 0);
        @(negedge clk);
        rstn = 1;
        drop_m1();
        set_m0(0, 0, 32'h10, 4'h0, 32'h0);
        #3;
        check("t5_idle_gnt", m0_gnt, 1);
        @(negedge clk);
        idle_inputs();
        #3;
        check("t5_no_write", m0_rdata, 32'hDEADBEEF);

        // Address wrap: upper bits ignored.
        @(negedge clk);
        set_m0(0, 0, 32'h2004, 4'h0, 32'h0);
        #3;
        check("t6_wrap_addr", ram_addr, 1);

        // Fresh reset, then a tie from the very first cycle.
        @(negedge clk);
        idle_inputs();
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_m0(0, 0, 32'h300, 4'h0, 32'h0);
            set_m1(0, 0, 32'h304, 4'h0, 32'h0);
            #3;
`ifdef RAM_ARB_RR_EN
            exp_m1 = (i % 2 == 1);
`else
            exp_m1 = 1'b0;
`endif
            check("t6_tie_m1_gnt", m1_gnt, exp_m1);
        end
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
